elixirchip_es1_spu_op_acc_multi: RTL and testbench

//  Multi-channel add/sub accumulator for the SPU op library. It holds CHANNELS independent accumulators
//  and, in each valid cycle, updates the one selected by s_ch (read-modify-write), with optional unsigned saturation.

---
 rtl/elixirchip_es1_spu_op_acc_multi_pkg.sv | 14 +
 rtl/elixirchip_es1_spu_op_acc_multi_if.sv | 29 ++
 rtl/elixirchip_es1_spu_op_acc_multi_nop.sv | 27 ++
 rtl/elixirchip_es1_spu_op_acc_multi.sv | 153 +++++++++++++++
 tb/tb_elixirchip_es1_spu_op_acc_multi.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/elixirchip_es1_spu_op_acc_multi_pkg.sv
// Shared types and helpers for the multi-channel SPU accumulator.
package elixirchip_es1_spu_acc_pkg;

  typedef enum logic {
    ACC_ADD = 1'b0,
    ACC_SUB = 1'b1
  } acc_op_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_bits(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_acc_multi_if.sv
// Operand/result bundle of the multi-channel accumulator (slave = accumulator side).
interface elixirchip_es1_spu_op_acc_multi_if #(
  parameter int CH_BITS     = 2,
  parameter int S_DATA_BITS = 8,
  parameter int M_DATA_BITS = 8
);
  logic [CH_BITS-1:0]     s_ch;
  logic                   s_sub;
  logic                   s_carry;
  logic [S_DATA_BITS-1:0] s_data;
  logic                   s_clear;
  logic                   s_clear_all;
  logic                   s_valid;
  logic [CH_BITS-1:0]     m_ch;
  logic                   m_carry;
  logic                   m_sat;
  logic [M_DATA_BITS-1:0] m_data;
  logic                   m_valid;

  modport master (
    output s_ch, s_sub, s_carry, s_data, s_clear, s_clear_all, s_valid,
    input  m_ch, m_carry, m_sat, m_data, m_valid
  );

  modport slave (
    input  s_ch, s_sub, s_carry, s_data, s_clear, s_clear_all, s_valid,
    output m_ch, m_carry, m_sat, m_data, m_valid
  );
endinterface

// File: rtl/elixirchip_es1_spu_op_acc_multi_nop.sv
// Pass-through delay line: LATENCY register stages with clock enable and synchronous clear.
module elixirchip_es1_spu_op_nop #(
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data,
  output logic [DATA_BITS-1:0] m_data
);

  logic [DATA_BITS-1:0] stage_r [LATENCY];

  // Shift register; reset flushes every in-flight word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) stage_r[i] <= '0;
    end else if (cke) begin
      stage_r[0] <= s_data;
      for (int i = 1; i < LATENCY; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign m_data = stage_r[LATENCY-1];

endmodule

// File: rtl/elixirchip_es1_spu_op_acc_multi.sv
// Multi-channel add/sub accumulator with single-cycle read-modify-write per channel.
// Optional unsigned saturation: define ELIXIRCHIP_ES1_SPU_OP_ACC_MULTI_SAT_EN.
module elixirchip_es1_spu_op_acc_multi
  import elixirchip_es1_spu_acc_pkg::*;
#(
  parameter int                     LATENCY     = 1,
  parameter int                     CHANNELS    = 4,
  parameter int                     S_DATA_BITS = 8,
  parameter int                     M_DATA_BITS = 8,
  parameter logic [M_DATA_BITS-1:0] CLEAR_DATA  = '0,
  parameter logic                   CLEAR_CARRY = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cke,
  elixirchip_es1_spu_op_acc_multi_if.slave bus
);

  localparam int CH_BITS = ch_bits(CHANNELS);
  localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS+1)'(CHANNELS);

  typedef struct packed {
    logic                   valid;
    logic [CH_BITS-1:0]     ch;
    logic                   carry;
    logic                   sat;
    logic [M_DATA_BITS-1:0] data;
  } acc_result_t;

  logic [M_DATA_BITS-1:0] acc_r      [CHANNELS];
  logic                   carry_r    [CHANNELS];
  logic [M_DATA_BITS-1:0] acc_next_s [CHANNELS];
  logic                   carry_next_s [CHANNELS];
  logic [M_DATA_BITS-1:0] operand_s, base_s, addend_s, sum_data_s, clamp_s;
  logic                   sum_carry_s, sat_s, ch_ok_s;
  acc_op_t                op_s;
  acc_result_t            res_s, res_r, out_s;

  if (S_DATA_BITS >= M_DATA_BITS) begin : g_trunc
    assign operand_s = bus.s_data[M_DATA_BITS-1:0];
  end else begin : g_zext
    assign operand_s = {{(M_DATA_BITS-S_DATA_BITS){1'b0}}, bus.s_data};
  end

  assign op_s    = acc_op_t'(bus.s_sub);
  assign ch_ok_s = ({1'b0, bus.s_ch} < CH_LIMIT);

  // Adder: a clear-with-valid starts the frame from CLEAR_DATA instead of the stored value.
  always_comb begin
    base_s = '0;
    if (bus.s_clear) begin
      base_s = CLEAR_DATA;
    end else if (ch_ok_s) begin
      base_s = acc_r[bus.s_ch];
    end else begin
      base_s = '0;
    end
    addend_s = (op_s == ACC_SUB) ? ~operand_s : operand_s;
    {sum_carry_s, sum_data_s} = {1'b0, base_s} + {1'b0, addend_s}
                              + {{M_DATA_BITS{1'b0}}, bus.s_carry};
  end

`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_MULTI_SAT_EN
  // Clamp on unsigned overflow (add) or borrow (sub); the raw carry is kept separately.
  always_comb begin
    sat_s   = 1'b0;
    clamp_s = sum_data_s;
    if ((op_s == ACC_ADD) && sum_carry_s) begin
      sat_s   = 1'b1;
      clamp_s = '1;
    end else if ((op_s == ACC_SUB) && !sum_carry_s) begin
      sat_s   = 1'b1;
      clamp_s = '0;
    end else begin
      sat_s   = 1'b0;
      clamp_s = sum_data_s;
    end
  end
`else
  assign sat_s   = 1'b0;
  assign clamp_s = sum_data_s;
`endif

  // Next state and result: clear_all beats clear beats accumulate; bad channels only echo.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      acc_next_s[i]   = acc_r[i];
      carry_next_s[i] = carry_r[i];
    end
    res_s = '0;
    if (bus.s_clear_all) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_next_s[i]   = CLEAR_DATA;
        carry_next_s[i] = CLEAR_CARRY;
      end
    end else if (!ch_ok_s) begin
      res_s.valid = bus.s_valid;
      res_s.ch    = bus.s_ch;
    end else if (bus.s_valid) begin
      acc_next_s[bus.s_ch]   = clamp_s;
      carry_next_s[bus.s_ch] = sum_carry_s;
      res_s.valid = 1'b1;
      res_s.ch    = bus.s_ch;
      res_s.carry = sum_carry_s;
      res_s.sat   = sat_s;
      res_s.data  = clamp_s;
    end else if (bus.s_clear) begin
      acc_next_s[bus.s_ch]   = CLEAR_DATA;
      carry_next_s[bus.s_ch] = CLEAR_CARRY;
    end else begin
      res_s = '0;
    end
  end

  // Accumulator array and first output stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i]   <= CLEAR_DATA;
        carry_r[i] <= CLEAR_CARRY;
      end
      res_r <= '0;
    end else if (cke) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i]   <= acc_next_s[i];
        carry_r[i] <= carry_next_s[i];
      end
      res_r <= res_s;
    end
  end

  if (LATENCY > 1) begin : g_pipe
    elixirchip_es1_spu_op_nop #(
      .DATA_BITS ($bits(acc_result_t)),
      .LATENCY   (LATENCY - 1)
    ) u_nop (
      .clk     (clk),
      .reset_n (reset_n),
      .cke     (cke),
      .s_data  (res_r),
      .m_data  (out_s)
    );
  end else begin : g_direct
    assign out_s = res_r;
  end

  assign bus.m_valid = out_s.valid;
  assign bus.m_ch    = out_s.ch;
  assign bus.m_carry = out_s.carry;
  assign bus.m_sat   = out_s.sat;
  assign bus.m_data  = out_s.data;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc_multi.sv
// Bench: a 4-channel and a 5-channel (out-of-range select) accumulator, LATENCY=2, against a per-channel sum model.
module tb_elixirchip_es1_spu_op_acc_multi;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n, cke;
  int compared = 0;
  int mismatched = 0;

  int acc_m [2][8];
  bit pv [2][LAT];
  int pch [2][LAT], pcar [2][LAT], psat [2][LAT], pd [2][LAT];
  int last4_ch, last4_car, last4_sat, last4_d;
  int last5_ch, last5_d, last5_car, seen5;

  elixirchip_es1_spu_op_acc_multi_if #(.CH_BITS(2), .S_DATA_BITS(8), .M_DATA_BITS(8)) bus4 ();
  elixirchip_es1_spu_op_acc_multi_if #(.CH_BITS(3), .S_DATA_BITS(8), .M_DATA_BITS(8)) bus5 ();

  elixirchip_es1_spu_op_acc_multi #(.LATENCY(LAT), .CHANNELS(4), .S_DATA_BITS(8), .M_DATA_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .bus(bus4));
  elixirchip_es1_spu_op_acc_multi #(.LATENCY(LAT), .CHANNELS(5), .S_DATA_BITS(8), .M_DATA_BITS(8)) dut5 (
    .clk(clk), .reset_n(reset_n), .cke(cke), .bus(bus5));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst_v, input bit ce_v, input int ch_v, input bit sub_v, input bit car_v,
                      input int d_v, input bit clr_v, input bit all_v, input bit vld_v);
    int nch, ch, base, opnd, tot, od;
    bit ov, oc, os;
    logic [31:0] o_v, o_ch, o_c, o_s, o_d;
    reset_n = rst_v; cke = ce_v;
    bus4.s_ch = 2'(ch_v);  bus5.s_ch = 3'(ch_v);
    bus4.s_sub = sub_v;    bus5.s_sub = sub_v;
    bus4.s_carry = car_v;  bus5.s_carry = car_v;
    bus4.s_data = 8'(d_v); bus5.s_data = 8'(d_v);
    bus4.s_clear = clr_v;  bus5.s_clear = clr_v;
    bus4.s_clear_all = all_v; bus5.s_clear_all = all_v;
    bus4.s_valid = vld_v;  bus5.s_valid = vld_v;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      nch = (k == 0) ? 4 : 5;
      ch  = (k == 0) ? (ch_v & 3) : (ch_v & 7);
      if (!rst_v) begin
        for (int i = 0; i < 8; i++) acc_m[k][i] = 0;
        for (int j = 0; j < LAT; j++) pv[k][j] = 1'b0;
      end else if (ce_v) begin
        ov = 1'b0; oc = 1'b0; os = 1'b0; od = 0;
        if (all_v) begin
          for (int i = 0; i < 8; i++) acc_m[k][i] = 0;
        end else if (ch >= nch) begin
          ov = vld_v;
        end else if (vld_v) begin
          base = clr_v ? 0 : acc_m[k][ch];
          opnd = sub_v ? 255 - (d_v & 255) : (d_v & 255);
          tot  = base + opnd + int'(car_v);
          oc   = (tot > 255);
          od   = tot % 256;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_MULTI_SAT_EN
          if (!sub_v && oc) begin od = 255; os = 1'b1; end
          if (sub_v && !oc) begin od = 0; os = 1'b1; end
`endif
          acc_m[k][ch] = od;
          ov = 1'b1;
        end else if (clr_v) begin
          acc_m[k][ch] = 0;
        end
        for (int j = LAT - 1; j > 0; j--) begin
          pv[k][j] = pv[k][j-1]; pch[k][j] = pch[k][j-1]; pcar[k][j] = pcar[k][j-1];
          psat[k][j] = psat[k][j-1]; pd[k][j] = pd[k][j-1];
        end
        pv[k][0] = ov; pch[k][0] = ch; pcar[k][0] = oc; psat[k][0] = os; pd[k][0] = od;
      end
      if (k == 0) begin
        o_v = 32'(bus4.m_valid); o_ch = 32'(bus4.m_ch); o_c = 32'(bus4.m_carry);
        o_s = 32'(bus4.m_sat); o_d = 32'(bus4.m_data);
      end else begin
        o_v = 32'(bus5.m_valid); o_ch = 32'(bus5.m_ch); o_c = 32'(bus5.m_carry);
        o_s = 32'(bus5.m_sat); o_d = 32'(bus5.m_data);
      end
      chk($sformatf("dut%0d_m_valid", nch), o_v, 32'(pv[k][LAT-1]));
      if (pv[k][LAT-1]) begin
        chk($sformatf("dut%0d_m_ch", nch), o_ch, 32'(pch[k][LAT-1]));
        chk($sformatf("dut%0d_m_carry", nch), o_c, 32'(pcar[k][LAT-1]));
        chk($sformatf("dut%0d_m_sat", nch), o_s, 32'(psat[k][LAT-1]));
        chk($sformatf("dut%0d_m_data", nch), o_d, 32'(pd[k][LAT-1]));
      end
    end
    if (bus4.m_valid === 1'b1) begin
      last4_ch = int'(bus4.m_ch); last4_car = int'(bus4.m_carry);
      last4_sat = int'(bus4.m_sat); last4_d = int'(bus4.m_data);
    end
    if (bus5.m_valid === 1'b1) begin
      last5_ch = int'(bus5.m_ch); last5_d = int'(bus5.m_data);
      last5_car = int'(bus5.m_carry); seen5++;
    end
  endtask

  task automatic add(input int ch, input int d);
    step(1'b1, 1'b1, ch, 1'b0, 1'b0, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int v4;
    // 1: reset, then 5 into every channel
    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset_m_valid", 32'(bus4.m_valid), 32'd0);
    chk("reset_m_data", 32'(bus4.m_data), 32'd0);
    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) add(c, 5);
    idle(); idle();
    chk("t1_last_ch", 32'(last4_ch), 32'd3);
    chk("t1_last_data", 32'(last4_d), 32'h05);
    // 2: ch1 frame starts at FF, then +2 wraps
    step(1'b1, 1'b1, 1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    add(1, 2);
    idle(); idle();
    chk("t2_carry", 32'(last4_car), 32'd1);
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_MULTI_SAT_EN
    chk("t2_data", 32'(last4_d), 32'hFF);
    chk("t2_sat", 32'(last4_sat), 32'd1);
`else
    chk("t2_data", 32'(last4_d), 32'h01);
    chk("t2_sat", 32'(last4_sat), 32'd0);
`endif
    // 3: ch2=3, subtract 5 with carry-in 1 -> borrow
    step(1'b1, 1'b1, 2, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    chk("t3_carry", 32'(last4_car), 32'd0);
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_MULTI_SAT_EN
    chk("t3_data", 32'(last4_d), 32'h00);
`else
    chk("t3_data", 32'(last4_d), 32'hFE);
`endif
    // 4: start-of-frame clear on ch3, then clear_all with an operand that must vanish
    step(1'b1, 1'b1, 3, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b1);
    idle(); idle();
    chk("t4_sof_data", 32'(last4_d), 32'h07);
    step(1'b1, 1'b1, 3, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
    idle(); idle();
    add(3, 8'h22);
    idle(); idle();
    chk("t4_after_clear_all", 32'(last4_d), 32'h22);
    // 5: interleaved same-channel updates with cke gaps
    step(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    add(0, 1);
    step(1'b1, 1'b0, 2, 1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b1);
    add(0, 1); add(1, 1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    add(0, 1);
    idle(); idle();
    chk("t5_last_ch0", 32'(last4_d), 32'h03);
    // 6: out-of-range channel on the 5-channel instance, then reset mid-stream
    seen5 = 0;
    add(5, 9);
    idle(); idle();
    chk("t6_oor_seen", 32'(seen5), 32'd1);
    chk("t6_oor_ch", 32'(last5_ch), 32'd5);
    chk("t6_oor_data", 32'(last5_d), 32'd0);
    add(0, 1);
    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    v4 = int'(bus4.m_valid);
    idle();
    chk("t6_flush_valid", 32'(v4 + int'(bus4.m_valid)), 32'd0);
    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      step(($urandom % 64) != 0, ($urandom % 8) != 0, int'($urandom % 8), 1'($urandom % 2),
           1'($urandom % 2), int'($urandom % 256), ($urandom % 8) == 0, ($urandom % 32) == 0,
           ($urandom % 4) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
